// File: rtl/vgpr_write_seq.sv
// Multi-beat VGPR write sequencer: accepts a request (base, count, exec, xmask),
// then streams up to four data beats to consecutive register addresses.
module vgpr_write_seq (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [9:0]    req_addr,
  input  logic [2:0]    req_cnt,
  input  logic [63:0]   req_exec,
  input  logic [3:0]    req_xmask,
  input  logic          dat_valid,
  output logic          dat_ready,
  input  logic [2047:0] dat_data,
  output logic [9:0]    wr0_addr,
  output logic [63:0]   wr0_en,
  output logic [3:0]    wr0_en_xoutof4,
  output logic [2047:0] wr0_data,
  output logic          busy,
  output logic          wb_done,
  output logic          req_err
);

  typedef enum logic [1:0] {IDLE, WRITE, ERR} state_t;

  state_t      state;
  logic [9:0]  base;
  logic [2:0]  cnt;
  logic [63:0] exec;
  logic [3:0]  xmask;
  logic [1:0]  idx;
  logic        last_beat;

  function automatic logic cnt_legal(input logic [2:0] c);
    return (c >= 3'd1) && (c <= 3'd4);
  endfunction

  // Handshake flags are pure decodes of the state register.
  assign req_ready = (state == IDLE);
  assign dat_ready = (state == WRITE);
  assign busy      = (state != IDLE);
  assign last_beat = ({1'b0, idx} == (cnt - 3'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      base           <= '0;
      cnt            <= '0;
      exec           <= '0;
      xmask          <= '0;
      idx            <= '0;
      wb_done        <= 1'b0;
      req_err        <= 1'b0;
      wr0_addr       <= '0;
      wr0_en         <= '0;
      wr0_en_xoutof4 <= '0;
      wr0_data       <= '0;
    end else begin
      // Enables and pulses default low; address and data hold between writes.
      wb_done        <= 1'b0;
      req_err        <= 1'b0;
      wr0_en         <= '0;
      wr0_en_xoutof4 <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (cnt_legal(req_cnt)) begin
              base  <= req_addr;
              cnt   <= req_cnt;
              exec  <= req_exec;
              xmask <= req_xmask;
              idx   <= '0;
              state <= WRITE;
            end else begin
              req_err <= 1'b1;
              state   <= ERR;
            end
          end
        end
        WRITE: begin
          if (dat_valid) begin
            // 10-bit sum wraps 1023 -> 0 naturally.
            wr0_addr       <= base + {8'b0, idx};
            wr0_en         <= exec;
            wr0_en_xoutof4 <= xmask;
            wr0_data       <= dat_data;
            if (last_beat) begin
              wb_done <= 1'b1;
              state   <= IDLE;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
